// File: rtl/second_tick_timer.sv
// Second-tick timer: synchronises the 1 Hz divider output, emits one-clk second pulses
// and runs a loadable seconds down-counter. Optional near-expiry warn: `define TIMER_WARN_EN.
module second_tick_timer #(
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int WARN_SECS   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_in,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             start,
   input  logic             abort,
   output logic             sec_pulse,
   output logic [CNT_W-1:0] remaining,
   output logic             busy,
   output logic             expired,
   output logic             warn
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOADED = 2'd1,
      ST_RUN    = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   if (SYNC_STAGES < 2 || WARN_SECS < 0) begin : g_bad_param
      $error("second_tick_timer: SYNC_STAGES must be >= 2 and WARN_SECS >= 0");
   end

   logic [SYNC_STAGES-1:0] sync_r;
   logic [SYNC_STAGES-1:0] vld_r;
   logic                   prev_r;
   logic                   armed_r;
   logic                   rise_s;
   logic                   sec_pulse_r;
   state_t                 state_r;
   state_t                 state_nx_s;
   logic [CNT_W-1:0]       rem_r;
   logic [CNT_W-1:0]       rem_nx_s;
   logic                   busy_r;
   logic                   expired_r;

   // vld_r marks when the sync output holds a real tick_in sample rather than reset zeros,
   // so a tick_in that is already high at reset release cannot arm the edge detector.
   assign rise_s = sync_r[SYNC_STAGES-1] & ~prev_r & armed_r;

   // Synchroniser chain, edge-detector history and second pulse register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r      <= {SYNC_STAGES{1'b0}};
         vld_r       <= {SYNC_STAGES{1'b0}};
         prev_r      <= 1'b0;
         armed_r     <= 1'b0;
         sec_pulse_r <= 1'b0;
      end else begin
         sync_r      <= {sync_r[SYNC_STAGES-2:0], tick_in};
         vld_r       <= {vld_r[SYNC_STAGES-2:0], 1'b1};
         prev_r      <= sync_r[SYNC_STAGES-1];
         armed_r     <= armed_r | (vld_r[SYNC_STAGES-1] & ~sync_r[SYNC_STAGES-1]);
         sec_pulse_r <= rise_s;
      end
   end

   // Next-state and next-count logic, command priority abort > load > start > sec_pulse
   always_comb begin
      state_nx_s = state_r;
      rem_nx_s   = rem_r;
      case (state_r)
         ST_IDLE: begin
            if (load) begin
               rem_nx_s   = load_val;
               state_nx_s = ST_LOADED;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LOADED: begin
            if (abort) begin
               rem_nx_s   = ZERO;
               state_nx_s = ST_IDLE;
            end else if (load) begin
               rem_nx_s = load_val;
            end else if (start) begin
               state_nx_s = (rem_r != ZERO) ? ST_RUN : ST_DONE;
            end else begin
               state_nx_s = ST_LOADED;
            end
         end
         ST_RUN: begin
            if (abort) begin
               rem_nx_s   = ZERO;
               state_nx_s = ST_IDLE;
            end else if (load) begin
               rem_nx_s   = load_val;
               state_nx_s = (load_val == ZERO) ? ST_DONE : ST_RUN;
            end else if (sec_pulse_r && rem_r > ONE) begin
               rem_nx_s = rem_r - ONE;
            end else if (sec_pulse_r) begin
               rem_nx_s   = ZERO;
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_DONE: begin
            rem_nx_s   = ZERO;
            state_nx_s = ST_IDLE;
         end
         default: begin
            rem_nx_s   = ZERO;
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State, counter and status flags registered from their next values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         rem_r     <= ZERO;
         busy_r    <= 1'b0;
         expired_r <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         rem_r     <= rem_nx_s;
         busy_r    <= (state_nx_s == ST_RUN);
         expired_r <= (state_nx_s == ST_DONE);
      end
   end

`ifdef TIMER_WARN_EN
   localparam logic [CNT_W-1:0] WARN_LIM = CNT_W'(WARN_SECS);
   logic warn_r;

   // Near-expiry flag, aligned with the remaining count it describes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warn_r <= 1'b0;
      end else begin
         warn_r <= (state_nx_s == ST_RUN) && (rem_nx_s != ZERO) && (rem_nx_s <= WARN_LIM);
      end
   end

   assign warn = warn_r;
`else
   assign warn = 1'b0;
`endif

   assign sec_pulse = sec_pulse_r;
   assign remaining = rem_r;
   assign busy      = busy_r;
   assign expired   = expired_r;

endmodule

// File: tb/tb_second_tick_timer.sv
// Directed bench for second_tick_timer: a spec-level model checked every cycle,
// plus literal expectations per scenario. Honours `define TIMER_WARN_EN.
module tb_second_tick_timer;

   localparam int CNT_W = 8;
   localparam int SYNC  = 2;
   localparam int WSECS = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             tick_in = 1'b1;
   logic             load = 1'b0;
   logic [CNT_W-1:0] load_val = 8'd0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             sec_pulse;
   logic [CNT_W-1:0] remaining;
   logic             busy;
   logic             expired;
   logic             warn;

   second_tick_timer #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .WARN_SECS(WSECS)) dut (
      .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .load(load), .load_val(load_val),
      .start(start), .abort(abort), .sec_pulse(sec_pulse), .remaining(remaining),
      .busy(busy), .expired(expired), .warn(warn)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_pulse = 0;
   int n_exp = 0;
   int n_busy = 0;
   int n_warn = 0;

   // Model: phase 0 idle, 1 holding a loaded duration, 2 counting, 3 expiry cycle
   int m_phase = 0;
   int m_rem = 0;
   bit m_pulse = 1'b0;
   bit tick_hist[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int n;
      bit new_pulse;
      if (!rst_n) begin
         m_phase = 0;
         m_rem   = 0;
         m_pulse = 1'b0;
         tick_hist.delete();
      end else begin
         if (m_phase == 0) begin
            if (load) begin m_rem = load_val; m_phase = 1; end
         end else if (m_phase == 1) begin
            if (abort) begin m_rem = 0; m_phase = 0; end
            else if (load) m_rem = load_val;
            else if (start) m_phase = (m_rem == 0) ? 3 : 2;
         end else if (m_phase == 2) begin
            if (abort) begin m_rem = 0; m_phase = 0; end
            else if (load) begin m_rem = load_val; if (m_rem == 0) m_phase = 3; end
            else if (m_pulse) begin m_rem = m_rem - 1; if (m_rem == 0) m_phase = 3; end
         end else begin
            m_rem = 0;
            m_phase = 0;
         end
         // pulse after edge k: tick sampled high at edge k-SYNC, genuinely low at k-SYNC-1
         tick_hist.push_back(tick_in);
         n = tick_hist.size();
         new_pulse = 1'b0;
         if (n >= SYNC + 2)
            new_pulse = tick_hist[n-1-SYNC] && !tick_hist[n-2-SYNC];
         if (n > SYNC + 2) void'(tick_hist.pop_front());
         m_pulse = new_pulse;
      end
   endtask

   // Per-cycle compare of every output against the model
   always @(posedge clk) begin
      bit exp_warn;
      model_step();
      #1;
`ifdef TIMER_WARN_EN
      exp_warn = (m_phase == 2) && (m_rem != 0) && (m_rem <= WSECS);
`else
      exp_warn = 1'b0;
`endif
      chk("sec_pulse", int'(sec_pulse), int'(m_pulse));
      chk("remaining", int'(remaining), m_rem);
      chk("busy", int'(busy), int'(m_phase == 2));
      chk("expired", int'(expired), int'(m_phase == 3));
      chk("warn", int'(warn), int'(exp_warn));
      if (sec_pulse) n_pulse++;
      if (expired) n_exp++;
      if (busy) n_busy++;
      if (warn) n_warn++;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cmd(input logic l, input logic s, input logic a, input logic [CNT_W-1:0] v);
      load = l; start = s; abort = a; load_val = v;
      @(negedge clk);
      load = 1'b0; start = 1'b0; abort = 1'b0;
   endtask

   task automatic tick();
      tick_in = 1'b1;
      cycles(4);
      tick_in = 1'b0;
      cycles(4);
   endtask

   task automatic clr_counts();
      n_pulse = 0; n_exp = 0; n_busy = 0; n_warn = 0;
   endtask

   initial begin
      int first;
      cycles(3);
      chk("reset_remaining", int'(remaining), 0);
      chk("reset_flags", int'({sec_pulse, busy, expired, warn}), 0);
      rst_n = 1'b1;
      clr_counts();

      // 1: high through reset release, then a genuine low-to-high edge
      cycles(20);
      chk("t1_no_pulse_while_high", n_pulse, 0);
      tick_in = 1'b0;
      cycles(5);
      tick_in = 1'b1;
      first = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #2;
         if (sec_pulse && first == 0) first = i;
      end
      @(negedge clk);
      chk("t1_pulse_latency", first, SYNC + 1);
      chk("t1_pulse_count", n_pulse, 1);
      tick_in = 1'b0;
      cycles(4);

      // 2: load 3, start, three seconds to expiry
      clr_counts();
      cmd(1'b1, 1'b0, 1'b0, 8'd3);
      cmd(1'b0, 1'b1, 1'b0, 8'd0);
      chk("t2_busy_after_start", int'(busy), 1);
      chk("t2_rem_after_start", int'(remaining), 3);
      tick();
      chk("t2_rem_after_tick1", int'(remaining), 2);
      tick();
      tick();
      chk("t2_expired_count", n_exp, 1);
      chk("t2_rem_final", int'(remaining), 0);
      chk("t2_busy_final", int'(busy), 0);

      // 3: abort mid-count
      clr_counts();
      cmd(1'b1, 1'b0, 1'b0, 8'd5);
      cmd(1'b0, 1'b1, 1'b0, 8'd0);
      tick();
      tick();
      chk("t3_rem_before_abort", int'(remaining), 3);
      cmd(1'b0, 1'b0, 1'b1, 8'd0);
      chk("t3_rem_after_abort", int'(remaining), 0);
      chk("t3_busy_after_abort", int'(busy), 0);
      tick();
      tick();
      chk("t3_rem_idle_ticks", int'(remaining), 0);
      chk("t3_no_expired", n_exp, 0);

      // 4: zero-length load, then load+start together
      clr_counts();
      cmd(1'b1, 1'b0, 1'b0, 8'd0);
      cmd(1'b0, 1'b1, 1'b0, 8'd0);
      cycles(2);
      chk("t4_zero_expired", n_exp, 1);
      chk("t4_zero_never_busy", n_busy, 0);
      cmd(1'b1, 1'b1, 1'b0, 8'd4);
      chk("t4_load_start_busy", int'(busy), 0);
      chk("t4_load_start_rem", int'(remaining), 4);
      tick();
      chk("t4_no_decrement_loaded", int'(remaining), 4);
      cmd(1'b0, 1'b0, 1'b1, 8'd0);

      // 5: reload while running
      clr_counts();
      cmd(1'b1, 1'b0, 1'b0, 8'd4);
      cmd(1'b0, 1'b1, 1'b0, 8'd0);
      tick();
      tick();
      chk("t5_rem_before_reload", int'(remaining), 2);
      cmd(1'b1, 1'b0, 1'b0, 8'd9);
      chk("t5_rem_reloaded", int'(remaining), 9);
      chk("t5_busy_reloaded", int'(busy), 1);
      for (int i = 0; i < 9; i++) tick();
      chk("t5_rem_final", int'(remaining), 0);
      chk("t5_expired_count", n_exp, 1);

      // 6: warn window over a six-second run
      clr_counts();
      cmd(1'b1, 1'b0, 1'b0, 8'd6);
      cmd(1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 7; i++) tick();
`ifdef TIMER_WARN_EN
      chk("t6_warn_cycles", n_warn, 24);
`else
      chk("t6_warn_cycles", n_warn, 0);
`endif
      chk("t6_expired_count", n_exp, 1);
      cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
